// File: rtl/chroni_pkg.sv
// Shared state encoding, size defaults and command helpers for the bitmap expander.
package chroni_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_EXPAND = 1'b1
   } state_t;

   localparam int LINE_SIZE_DEF = 1280;
   localparam int ADDR_W_DEF    = 11;

   // Commands may request up to 15 pixels; a byte only carries 8.
   function automatic logic [3:0] clamp_bits(input logic [3:0] bits);
      return (bits > 4'd8) ? 4'd8 : bits;
   endfunction

endpackage

// File: rtl/chroni_bitmap_expander.sv
// Expands font bitmap bytes into palette-index writes for an external line buffer, one pixel per cycle.
// Optional CHRONI_EXP_TRANSPARENT_EN: 0 bits with off index 0 skip the write but still advance.
module chroni_bitmap_expander
   import chroni_pkg::*;
#(
   parameter int LINE_SIZE = LINE_SIZE_DEF,
   parameter int ADDR_W    = ADDR_W_DEF
) (
   input  logic              sys_clk,
   input  logic              reset_n,
   input  logic              frame_start,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic [7:0]        wr_bitmap_on,
   input  logic [7:0]        wr_bitmap_off,
   input  logic [3:0]        wr_bitmap_bits,
   output logic              wr_busy,
   output logic              wr_overrun,
   output logic              px_we,
   output logic [ADDR_W-1:0] px_addr,
   output logic [7:0]        px_data
);

   state_t            state;
   logic [7:0]        shreg;
   logic [7:0]        on_idx;
   logic [7:0]        off_idx;
   logic [3:0]        remain;
   logic [ADDR_W-1:0] next_addr;
   logic              first_we;
   logic              next_we;

   function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
      return (a == ADDR_W'(LINE_SIZE - 1)) ? '0 : a + 1'b1;
   endfunction

   always_comb begin
      first_we = 1'b1;
      next_we  = 1'b1;
`ifdef CHRONI_EXP_TRANSPARENT_EN
      first_we = wr_data[7] | (wr_bitmap_off != 8'h00);
      next_we  = shreg[7] | (off_idx != 8'h00);
`endif
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         wr_busy    <= 1'b0;
         wr_overrun <= 1'b0;
         px_we      <= 1'b0;
         px_addr    <= '0;
         px_data    <= 8'h00;
         shreg      <= 8'h00;
         on_idx     <= 8'h00;
         off_idx    <= 8'h00;
         remain     <= 4'd0;
         next_addr  <= '0;
      end else if (frame_start) begin
         state      <= ST_IDLE;
         wr_busy    <= 1'b0;
         wr_overrun <= 1'b0;
         px_we      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (wr_en && wr_bitmap_bits == 4'd0) begin
                  px_we   <= 1'b1;
                  px_addr <= wr_addr;
                  px_data <= wr_data;
               end else if (wr_en) begin
                  // The first pixel goes out with the accepting edge; the rest follow from the latches.
                  px_we     <= first_we;
                  px_addr   <= wr_addr;
                  px_data   <= wr_data[7] ? wr_bitmap_on : wr_bitmap_off;
                  shreg     <= {wr_data[6:0], 1'b0};
                  on_idx    <= wr_bitmap_on;
                  off_idx   <= wr_bitmap_off;
                  remain    <= clamp_bits(wr_bitmap_bits) - 4'd1;
                  next_addr <= wrap_inc(wr_addr);
                  state     <= ST_EXPAND;
                  wr_busy   <= 1'b1;
               end else begin
                  px_we <= 1'b0;
               end
            end
            ST_EXPAND: begin
               if (wr_en) begin
                  wr_overrun <= 1'b1;
               end
               if (remain == 4'd0) begin
                  state   <= ST_IDLE;
                  wr_busy <= 1'b0;
                  px_we   <= 1'b0;
               end else begin
                  px_we     <= next_we;
                  px_addr   <= next_addr;
                  px_data   <= shreg[7] ? on_idx : off_idx;
                  shreg     <= {shreg[6:0], 1'b0};
                  remain    <= remain - 4'd1;
                  next_addr <= wrap_inc(next_addr);
               end
            end
            default: begin
               state   <= ST_IDLE;
               wr_busy <= 1'b0;
               px_we   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chroni_bitmap_expander.sv
// Scoreboard bench: the driver predicts every line-buffer write from the command rules, a monitor checks each cycle.
module tb_chroni_bitmap_expander;

   localparam int LINE_SIZE = 1280;
   localparam int ADDR_W    = 11;

   logic              sys_clk;
   logic              reset_n;
   logic              frame_start;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic [7:0]        wr_bitmap_on;
   logic [7:0]        wr_bitmap_off;
   logic [3:0]        wr_bitmap_bits;
   logic              wr_busy;
   logic              wr_overrun;
   logic              px_we;
   logic [ADDR_W-1:0] px_addr;
   logic [7:0]        px_data;

   chroni_bitmap_expander #(.LINE_SIZE(LINE_SIZE), .ADDR_W(ADDR_W)) dut (
      .sys_clk(sys_clk),
      .reset_n(reset_n),
      .frame_start(frame_start),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .wr_bitmap_on(wr_bitmap_on),
      .wr_bitmap_off(wr_bitmap_off),
      .wr_bitmap_bits(wr_bitmap_bits),
      .wr_busy(wr_busy),
      .wr_overrun(wr_overrun),
      .px_we(px_we),
      .px_addr(px_addr),
      .px_data(px_data)
   );

   typedef struct {
      int cyc;
      int addr;
      int data;
   } pix_t;

   pix_t q[$];
   int   cyc      = 0;
   int   busy_end = -1;
   bit   exp_ovr  = 0;
   bit   in_reset = 1;
   int   errors   = 0;
   int   checks   = 0;

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   // Reference: a command issued in cycle c produces pixel i in cycle c+1+i at (addr+i) mod LINE_SIZE.
   task automatic step(input bit en, input int addr, input int data, input int on,
                       input int off, input int bits, input bit fs);
      int c;
      int n;
      int b;
      bit we;
      @(negedge sys_clk);
      #1;
      c              = cyc;
      wr_en          = en;
      wr_addr        = ADDR_W'(addr);
      wr_data        = 8'(data);
      wr_bitmap_on   = 8'(on);
      wr_bitmap_off  = 8'(off);
      wr_bitmap_bits = 4'(bits);
      frame_start    = fs;
      if (fs) begin
         while (q.size() > 0 && q[$].cyc > c) void'(q.pop_back());
         if (busy_end > c) busy_end = c;
         exp_ovr = 0;
      end else if (en) begin
         if (c <= busy_end) begin
            exp_ovr = 1;
         end else begin
            n = (bits > 8) ? 8 : bits;
            if (n == 0) begin
               q.push_back('{c + 1, addr, data});
            end else begin
               for (int i = 0; i < n; i++) begin
                  b  = (data >> (7 - i)) & 1;
                  we = 1;
`ifdef CHRONI_EXP_TRANSPARENT_EN
                  if (b == 0 && off == 0) we = 0;
`endif
                  if (we) q.push_back('{c + 1 + i, (addr + i) % LINE_SIZE, b ? on : off});
               end
               busy_end = c + n;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin : monitor
      forever begin
         @(negedge sys_clk);
         if (!in_reset) begin
            check("busy", wr_busy, (cyc <= busy_end) ? 1 : 0);
            check("overrun", wr_overrun, exp_ovr);
            while (q.size() > 0 && q[0].cyc < cyc) begin
               checks++;
               errors++;
               $display("FAIL missing_write cyc=%0d got=none want=addr %0d at cyc %0d",
                        cyc, q[0].addr, q[0].cyc);
               void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
               check("px_we", px_we, 1);
               check("px_addr", px_addr, q[0].addr);
               check("px_data", px_data, q[0].data);
               void'(q.pop_front());
            end else begin
               check("px_we_quiet", px_we, 0);
            end
         end
      end
   end

   initial begin : driver
      int bits;
      int addr;
      int off;
      int r;
      reset_n        = 1'b0;
      frame_start    = 1'b0;
      wr_en          = 1'b0;
      wr_addr        = '0;
      wr_data        = 8'h00;
      wr_bitmap_on   = 8'h00;
      wr_bitmap_off  = 8'h00;
      wr_bitmap_bits = 4'd0;
      #2;
      check("rst_busy", wr_busy, 0);
      check("rst_overrun", wr_overrun, 0);
      check("rst_px_we", px_we, 0);
      check("rst_px_addr", px_addr, 0);
      check("rst_px_data", px_data, 0);
      @(negedge sys_clk);
      #1;
      reset_n  = 1'b1;
      in_reset = 0;

      // Alternating bitmap at address 0
      step(1, 0, 'hA5, 'h0F, 'h01, 8, 0);
      idle(9);
      // Raw write
      step(1, 640, 'h3C, 0, 0, 0, 0);
      idle(2);
      // Wrap at the end of the line
      step(1, 1277, 'hFF, 'h22, 'h11, 5, 0);
      idle(6);
      // Overrun during expansion, then a command right when idle returns
      step(1, 10, 'h96, 'h33, 'h44, 8, 0);
      idle(2);
      step(1, 500, 'hFF, 'h01, 'h02, 8, 0);
      idle(5);
      step(1, 20, 'h5A, 'h07, 'h08, 8, 0);
      idle(9);
      step(0, 0, 0, 0, 0, 0, 1);
      idle(2);
      // Abort mid-expansion
      step(1, 30, 'hC3, 'h09, 'h0A, 8, 0);
      idle(3);
      step(1, 99, 'h11, 1, 1, 3, 1);
      idle(4);
      // Asynchronous reset mid-expansion
      step(1, 100, 'hC3, 'h0B, 'h0C, 8, 0);
      idle(1);
      @(negedge sys_clk);
      #1;
      in_reset = 1;
      reset_n  = 1'b0;
      wr_en    = 1'b0;
      #1;
      check("arst_busy", wr_busy, 0);
      check("arst_overrun", wr_overrun, 0);
      check("arst_px_we", px_we, 0);
      check("arst_px_addr", px_addr, 0);
      check("arst_px_data", px_data, 0);
      q.delete();
      busy_end = -1;
      exp_ovr  = 0;
      @(negedge sys_clk);
      #1;
      reset_n  = 1'b1;
      in_reset = 0;
      step(1, 200, 'h6E, 'h0D, 'h0E, 4, 0);
      idle(5);
      // Off index 0 with sparse bitmap
      step(1, 300, 'h81, 'h05, 'h00, 8, 0);
      idle(9);

      for (int k = 0; k < 1500; k++) begin
         r = $urandom_range(0, 99);
         if (r < 3) begin
            step(0, 0, 0, 0, 0, 0, 1);
         end else if (r < 60) begin
            bits = $urandom_range(0, 15);
            addr = ($urandom_range(0, 4) == 0) ? $urandom_range(LINE_SIZE - 10, LINE_SIZE - 1)
                                               : $urandom_range(0, LINE_SIZE - 1);
            off  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
            step(1, addr, $urandom_range(0, 255), $urandom_range(0, 255), off, bits,
                 ($urandom_range(0, 49) == 0));
         end else begin
            idle(1);
         end
      end
      idle(12);
      check("drain", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
